phy_reg_free_list: RTL and testbench

- Circular free list of physical register numbers, one instance per register class (int/fp).
- Commit/recovery logic pushes released physical registers into it, up to PUSH_WIDTH per cycle, from its registered release outputs.
- Rename stage pops up to POP_WIDTH free registers per cycle for destination allocation.
- After reset, a self-initialisation phase fills the list with every non-architectural register before allocation is enabled.

---
 rtl/phy_reg_free_list.sv | 141 ++++++++++++++
 tb/tb_phy_reg_free_list.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/phy_reg_free_list.sv
// phy_reg_free_list: circular free list of physical registers, self-filling after reset; PHY_REG_FREE_LIST_DUP_CHECK_EN adds a sticky double-free / stale-pop detector
module phy_reg_free_list #(
  parameter int PHY_REG_NUM     = 64,
  parameter int LOGICAL_REG_NUM = 32,
  parameter int PUSH_WIDTH      = 2,
  parameter int POP_WIDTH       = 2,
  localparam int PW        = $clog2(PHY_REG_NUM),
  localparam int ENTRY_NUM = PHY_REG_NUM - LOGICAL_REG_NUM,
  localparam int PTRW      = $clog2(ENTRY_NUM),
  localparam int CW        = $clog2(ENTRY_NUM + 1),
  localparam int NW        = $clog2(POP_WIDTH + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [PUSH_WIDTH-1:0]      releaseReg,
  input  logic [PUSH_WIDTH*PW-1:0]   phyReleasedReg,
  input  logic [NW-1:0]              popNum,
  output logic                       allocReady,
  output logic [POP_WIDTH*PW-1:0]    allocReg,
  output logic [CW-1:0]              freeCount,
  output logic                       initDone,
  output logic                       dupError
);
  typedef enum logic {INIT, ACTIVE} state_t;
  state_t r_state, w_state_nxt;
  logic [PW-1:0] r_mem [ENTRY_NUM];
  logic [PTRW-1:0] r_head, r_tail, w_head_nxt, w_tail_nxt;
  logic [CW-1:0] r_count, w_count_nxt;
  logic [PUSH_WIDTH-1:0] w_we;
  logic [PTRW-1:0] w_waddr [PUSH_WIDTH];
  logic [PW-1:0] w_wdata [PUSH_WIDTH];
  logic [PW-1:0] w_rd [POP_WIDTH];
  logic [NW-1:0] w_pop;
  logic w_ready;

  function automatic logic [PTRW-1:0] wrap(input int s);
    return PTRW'(s >= ENTRY_NUM ? s - ENTRY_NUM : s);
  endfunction

  assign w_ready = r_state == ACTIVE && int'(r_count) >= POP_WIDTH;
  // An illegal pop request is dropped entirely rather than partially honoured
  assign w_pop = (r_state == ACTIVE && int'(popNum) <= int'(r_count) && int'(popNum) <= POP_WIDTH) ? popNum : '0;
  assign allocReady = w_ready;
  assign freeCount = r_count;
  assign initDone = r_state == ACTIVE;

  for (genvar i = 0; i < POP_WIDTH; i++) begin : g_rd
    assign w_rd[i] = r_mem[wrap(int'(r_head) + i)];
    assign allocReg[i*PW +: PW] = w_ready ? w_rd[i] : '0;
  end

  always_comb begin
    int n;
    n = 0;
    w_state_nxt = r_state;
    w_head_nxt = r_head;
    w_tail_nxt = r_tail;
    w_count_nxt = r_count;
    w_we = '0;
    for (int i = 0; i < PUSH_WIDTH; i++) begin
      w_waddr[i] = '0;
      w_wdata[i] = '0;
    end
    if (r_state == INIT) begin
      for (int i = 0; i < PUSH_WIDTH; i++) begin
        w_we[i] = int'(r_tail) + i < ENTRY_NUM;
        w_waddr[i] = PTRW'(int'(r_tail) + i);
        w_wdata[i] = PW'(LOGICAL_REG_NUM + int'(r_tail) + i);
      end
      w_state_nxt = int'(r_tail) + PUSH_WIDTH >= ENTRY_NUM ? ACTIVE : INIT;
      w_tail_nxt = int'(r_tail) + PUSH_WIDTH >= ENTRY_NUM ? '0 : PTRW'(int'(r_tail) + PUSH_WIDTH);
      w_count_nxt = int'(r_tail) + PUSH_WIDTH >= ENTRY_NUM ? CW'(ENTRY_NUM) : CW'(int'(r_count) + PUSH_WIDTH);
    end else begin
      for (int i = 0; i < PUSH_WIDTH; i++)
        if (releaseReg[i] && int'(r_count) - int'(w_pop) + n < ENTRY_NUM) begin
          w_we[i] = 1'b1;
          w_waddr[i] = wrap(int'(r_tail) + n);
          w_wdata[i] = phyReleasedReg[i*PW +: PW];
          n++;
        end
      w_head_nxt = wrap(int'(r_head) + int'(w_pop));
      w_tail_nxt = wrap(int'(r_tail) + n);
      w_count_nxt = CW'(int'(r_count) + n - int'(w_pop));
    end
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state <= INIT;
      r_head <= '0;
      r_tail <= '0;
      r_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_head <= w_head_nxt;
      r_tail <= w_tail_nxt;
      r_count <= w_count_nxt;
    end

  always_ff @(posedge clk)
    for (int i = 0; i < PUSH_WIDTH; i++)
      if (w_we[i]) r_mem[w_waddr[i]] <= w_wdata[i];

`ifdef PHY_REG_FREE_LIST_DUP_CHECK_EN
  logic [PHY_REG_NUM-1:0] r_free_vec, w_free_vec_nxt;
  logic r_dup, w_dup_nxt;
  // Pops clear first so a register recycled within one cycle is not a false duplicate
  always_comb begin
    w_free_vec_nxt = r_free_vec;
    w_dup_nxt = r_dup;
    for (int i = 0; i < POP_WIDTH; i++)
      if (i < int'(w_pop)) begin
        w_dup_nxt = w_dup_nxt | !w_free_vec_nxt[w_rd[i]];
        w_free_vec_nxt[w_rd[i]] = 1'b0;
      end
    for (int i = 0; i < PUSH_WIDTH; i++)
      if (w_we[i]) begin
        w_dup_nxt = w_dup_nxt | (r_state == ACTIVE && w_free_vec_nxt[w_wdata[i]]);
        w_free_vec_nxt[w_wdata[i]] = 1'b1;
      end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_free_vec <= '0;
      r_dup <= 1'b0;
    end else begin
      r_free_vec <= w_free_vec_nxt;
      r_dup <= w_dup_nxt;
    end
  assign dupError = r_dup;
`else
  assign dupError = 1'b0;
`endif

  a_init_idle: assert property (@(posedge clk) disable iff (rst)
    r_state == INIT |-> releaseReg == '0 && popNum == '0);
  a_pop_legal: assert property (@(posedge clk) disable iff (rst)
    r_state == ACTIVE |-> int'(popNum) <= int'(r_count) && int'(popNum) <= POP_WIDTH);
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    r_state == ACTIVE |-> int'(r_count) + $countones(releaseReg) - int'(popNum) <= ENTRY_NUM);
endmodule

// File: tb/tb_phy_reg_free_list.sv
// tb_phy_reg_free_list: directed vector table plus hand-written reset and duplicate-detection sequences
module tb_phy_reg_free_list;
  logic clk = 1'b0, rst;
  logic [1:0] releaseReg, popNum;
  logic [11:0] phyReleasedReg, allocReg;
  logic allocReady, initDone, dupError;
  logic [5:0] freeCount;
  int checks = 0, failures = 0;

  typedef struct {
    logic [1:0] rel;
    logic [11:0] phy;
    logic [1:0] pop;
    logic rdy;
    logic [11:0] alloc;
    logic [5:0] cnt;
  } vec_t;
  vec_t tbl[$];

  phy_reg_free_list dut (
    .clk(clk), .rst(rst), .releaseReg(releaseReg), .phyReleasedReg(phyReleasedReg),
    .popNum(popNum), .allocReady(allocReady), .allocReg(allocReg),
    .freeCount(freeCount), .initDone(initDone), .dupError(dupError)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle();
    releaseReg = '0;
    phyReleasedReg = '0;
    popNum = '0;
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, " rdy"}, 32'(allocReady), 0);
    chk({nm, " alloc"}, 32'(allocReg), 0);
    chk({nm, " cnt"}, 32'(freeCount), 0);
    chk({nm, " init"}, 32'(initDone), 0);
  endtask

  task automatic run_init(input string nm);
    for (int c = 1; c <= 16; c++) begin
      tick();
      if (c == 15) chk({nm, " init15"}, 32'(initDone), 0);
    end
    chk({nm, " init16"}, 32'(initDone), 1);
    chk({nm, " rdy16"}, 32'(allocReady), 1);
    chk({nm, " cnt16"}, 32'(freeCount), 32);
    chk({nm, " alloc16"}, 32'(allocReg), {20'd0, 6'd33, 6'd32});
  endtask

  function automatic vec_t mk(logic [1:0] rel, int l0, int l1, logic [1:0] pop,
                              logic rdy, int a0, int a1, int cnt);
    vec_t v;
    v.rel = rel;
    v.phy = {6'(l1), 6'(l0)};
    v.pop = pop;
    v.rdy = rdy;
    v.alloc = {6'(a1), 6'(a0)};
    v.cnt = 6'(cnt);
    return v;
  endfunction

  initial begin
    for (int i = 0; i < 16; i++) tbl.push_back(mk(0, 0, 0, 2, 1, 32 + 2*i, 33 + 2*i, 32 - 2*i));
    tbl.push_back(mk(2'b10, 63, 5, 0, 0, 0, 0, 0));
    tbl.push_back(mk(2'b01, 7, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 2, 1, 5, 7, 2));
    for (int j = 0; j < 16; j++) tbl.push_back(mk(3, 2*j, 2*j + 1, 0, j > 0, 0, j > 0 ? 1 : 0, 2*j));
    for (int r = 0; r < 14; r++) tbl.push_back(mk(3, 32 + 2*r, 33 + 2*r, 2, 1, 2*r, 2*r + 1, 32));
    tbl.push_back(mk(3, 9, 10, 2, 1, 28, 29, 32));
    for (int d = 0; d < 16; d++)
      tbl.push_back(mk(0, 0, 0, 2, 1, d == 0 ? 30 : d == 15 ? 9 : 30 + 2*d,
                       d == 0 ? 31 : d == 15 ? 10 : 31 + 2*d, 32 - 2*d));
    tbl.push_back(mk(3, 20, 21, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 1, 20, 21, 2));
    tbl.push_back(mk(1, 22, 0, 1, 0, 0, 0, 1));
    tbl.push_back(mk(2, 0, 23, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 2, 1, 22, 23, 2));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));

    rst = 1'b1;
    idle();
    #2;
    chk_reset_vals("por");
    chk("por dup", 32'(dupError), 0);
    tick();
    rst = 1'b0;
    run_init("init");

    foreach (tbl[i]) begin
      releaseReg = tbl[i].rel;
      phyReleasedReg = tbl[i].phy;
      popNum = tbl[i].pop;
      chk($sformatf("v%0d rdy", i), 32'(allocReady), 32'(tbl[i].rdy));
      chk($sformatf("v%0d alloc", i), 32'(allocReg), 32'(tbl[i].alloc));
      chk($sformatf("v%0d cnt", i), 32'(freeCount), 32'(tbl[i].cnt));
      chk($sformatf("v%0d init", i), 32'(initDone), 1);
      tick();
    end
    idle();
    chk("table dup", 32'(dupError), 0);

    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (8) tick();
    #2 rst = 1'b1;
    #1 chk_reset_vals("rst_init");
    #1 rst = 1'b0;
    run_init("reinit");

    popNum = 2;
    repeat (6) tick();
    popNum = 0;
    chk("pre_rst cnt", 32'(freeCount), 20);
    #2 rst = 1'b1;
    #1 chk_reset_vals("rst_active");
    #1 rst = 1'b0;
    run_init("reinit2");

`ifdef PHY_REG_FREE_LIST_DUP_CHECK_EN
    popNum = 2;
    tick();
    popNum = 0;
    chk("dup pre", 32'(dupError), 0);
    releaseReg = 2'b01;
    phyReleasedReg = 12'd40;
    tick();
    idle();
    chk("dup set", 32'(dupError), 1);
    repeat (3) tick();
    chk("dup held", 32'(dupError), 1);
    rst = 1'b1;
    #1 chk("dup rst", 32'(dupError), 0);
    #1 rst = 1'b0;
`else
    chk("dup off", 32'(dupError), 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
